// File: rtl/workout_sequencer.sv
// workout_sequencer: work/rest interval sequencer for a training session.
// Counts sets up to a target latched at session start, times each interval
// from a one-second tick enable, inserts a periodic long rest, supports
// pause/resume and skip, and steps an exercise wheel on every new set.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no session; waits for a start request with a nonzero target
//   WORK   | work interval of set Cn, Ti ticks remaining
//   REST   | rest after set Cn (never after the final set)
//   PAUSED | counters frozen; Pa returns to the saved WORK/REST state
module workout_sequencer #(
  parameter int CN_W          = 9,
  parameter int TI_W          = 7,
  parameter int WORK_SEC      = 45,
  parameter int REST_SEC      = 15,
  parameter int LONG_REST_SEC = 60,
  parameter int LONG_EVERY    = 5,
  parameter int NUM_EX        = 10
) (
  input  logic            Clk,
  input  logic            Re,
  input  logic            Tick,
  input  logic            St,
  input  logic            Sk,
  input  logic            Pa,
  input  logic [CN_W-1:0] Tgt,
  output logic [1:0]      Bu,
  output logic [CN_W-1:0] Cn,
  output logic [TI_W-1:0] Ti,
  output logic [3:0]      WCn,
  output logic [1:0]      St_o
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_WORK   = 2'b01;
  localparam logic [1:0] S_REST   = 2'b10;
  localparam logic [1:0] S_PAUSED = 2'b11;

  localparam logic [1:0] BU_NONE = 2'b00;
  localparam logic [1:0] BU_REST = 2'b01;
  localparam logic [1:0] BU_SKIP = 2'b10;
  localparam logic [1:0] BU_DONE = 2'b11;

  // Position of the current set inside a long-rest group runs 1..LONG_EVERY.
  localparam int LG_W = (LONG_EVERY < 2) ? 1 : $clog2(LONG_EVERY + 1);

  localparam logic [TI_W-1:0] WORK_TI = TI_W'(WORK_SEC);
  localparam logic [TI_W-1:0] REST_TI = TI_W'(REST_SEC);
  localparam logic [TI_W-1:0] LONG_TI = TI_W'(LONG_REST_SEC);
  localparam logic [3:0]      WHEEL_LAST = 4'(NUM_EX - 1);
  localparam logic [LG_W-1:0] GRP_LAST   = LG_W'(LONG_EVERY);

  // Reject parameter sets whose interval lengths or wheel size do not fit.
  if (WORK_SEC < 0 || WORK_SEC >= (1 << TI_W)) begin : g_chk_work
    $error("workout_sequencer: WORK_SEC does not fit in TI_W bits");
  end
  if (REST_SEC < 0 || REST_SEC >= (1 << TI_W)) begin : g_chk_rest
    $error("workout_sequencer: REST_SEC does not fit in TI_W bits");
  end
  if (LONG_REST_SEC < 0 || LONG_REST_SEC >= (1 << TI_W)) begin : g_chk_long
    $error("workout_sequencer: LONG_REST_SEC does not fit in TI_W bits");
  end
  if (NUM_EX < 1 || NUM_EX > 16) begin : g_chk_wheel
    $error("workout_sequencer: NUM_EX must be in 1..16");
  end
  if (LONG_EVERY < 0) begin : g_chk_every
    $error("workout_sequencer: LONG_EVERY must be non-negative");
  end

  logic [1:0]      state;
  logic [1:0]      ret_state;
  logic [CN_W-1:0] tgt_q;
  logic [LG_W-1:0] grp_cnt;

  logic [1:0]      state_nxt;
  logic [1:0]      ret_nxt;
  logic [CN_W-1:0] tgt_nxt;
  logic [LG_W-1:0] grp_nxt;
  logic [CN_W-1:0] cn_nxt;
  logic [TI_W-1:0] ti_nxt;
  logic [3:0]      wcn_nxt;
  logic [1:0]      bu_nxt;

  logic            last_set;
  logic            ti_zero;
  logic            long_due;
  logic            do_finish;
  logic            do_adv;
  logic [1:0]      adv_bu;

  assign last_set = (Cn == tgt_q);
  assign ti_zero  = (Ti == '0);
  assign long_due = (LONG_EVERY != 0) && (grp_cnt == GRP_LAST);
  assign St_o     = state;

  // Decode the per-state request (Sk > Pa > Tick) into next-state values.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    tgt_nxt   = tgt_q;
    grp_nxt   = grp_cnt;
    cn_nxt    = Cn;
    ti_nxt    = Ti;
    wcn_nxt   = WCn;
    bu_nxt    = BU_NONE;
    do_finish = 1'b0;
    do_adv    = 1'b0;
    adv_bu    = BU_NONE;

    case (state)
      S_IDLE: begin
        if (St && (Tgt != '0)) begin
          tgt_nxt   = Tgt;
          cn_nxt    = CN_W'(1);
          ti_nxt    = WORK_TI;
          wcn_nxt   = 4'd0;
          grp_nxt   = LG_W'(1);
          state_nxt = S_WORK;
        end
      end

      S_WORK: begin
        if (Sk) begin
          if (last_set) begin
            do_finish = 1'b1;
          end else begin
            do_adv = 1'b1;
            adv_bu = BU_SKIP;
          end
        end else if (Pa) begin
          ret_nxt   = S_WORK;
          state_nxt = S_PAUSED;
        end else if (Tick) begin
          if (!ti_zero) begin
            ti_nxt = Ti - TI_W'(1);
          end else if (last_set) begin
            do_finish = 1'b1;
          end else begin
            state_nxt = S_REST;
            ti_nxt    = long_due ? LONG_TI : REST_TI;
          end
        end
      end

      S_REST: begin
        if (Sk) begin
          do_adv = 1'b1;
          adv_bu = BU_SKIP;
        end else if (Pa) begin
          ret_nxt   = S_REST;
          state_nxt = S_PAUSED;
        end else if (Tick) begin
          if (!ti_zero) begin
            ti_nxt = Ti - TI_W'(1);
          end else begin
            do_adv = 1'b1;
            adv_bu = BU_REST;
          end
        end
      end

      default: begin
        if (Pa) begin
          state_nxt = ret_state;
        end
      end
    endcase

    // Advance to the next set; the group position restarts after a long-rest set.
    if (do_adv) begin
      cn_nxt    = Cn + CN_W'(1);
      ti_nxt    = WORK_TI;
      wcn_nxt   = (WCn == WHEEL_LAST) ? 4'd0 : WCn + 4'd1;
      grp_nxt   = long_due ? LG_W'(1) : grp_cnt + LG_W'(1);
      bu_nxt    = adv_bu;
      state_nxt = S_WORK;
    end

    // Session complete: Cn keeps the final set number for the display.
    if (do_finish) begin
      ti_nxt    = '0;
      wcn_nxt   = 4'd0;
      bu_nxt    = BU_DONE;
      state_nxt = S_IDLE;
    end
  end

  // Register every output and the internal session context.
  always_ff @(posedge Clk or negedge Re) begin
    if (!Re) begin
      state     <= S_IDLE;
      ret_state <= S_WORK;
      tgt_q     <= '0;
      grp_cnt   <= '0;
      Cn        <= '0;
      Ti        <= '0;
      WCn       <= 4'd0;
      Bu        <= BU_NONE;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      tgt_q     <= tgt_nxt;
      grp_cnt   <= grp_nxt;
      Cn        <= cn_nxt;
      Ti        <= ti_nxt;
      WCn       <= wcn_nxt;
      Bu        <= bu_nxt;
    end
  end

endmodule

// File: tb/tb_workout_sequencer.sv
// Bench for workout_sequencer: two instances with different parameter sets
// share one stimulus stream; a set-level model of each session is compared
// against both every cycle, with literal expectations for the planned cases.
module tb_workout_sequencer;

  typedef struct {
    int st;
    int cn;
    int ti;
    int wcn;
    int bu;
    int tgt;
    int ret;
  } mst_t;

  typedef struct {
    int work;
    int rest;
    int lrest;
    int every;
    int nex;
  } prm_t;

  localparam prm_t PRM_A = '{work: 3, rest: 2, lrest: 4, every: 2, nex: 3};
  localparam prm_t PRM_B = '{work: 5, rest: 3, lrest: 7, every: 0, nex: 10};

  logic       clk;
  logic       re;
  logic       tick;
  logic       st;
  logic       sk;
  logic       pa;
  logic [8:0] tgt;

  logic [1:0] a_bu, b_bu;
  logic [8:0] a_cn, b_cn;
  logic [6:0] a_ti;
  logic [3:0] b_ti;
  logic [3:0] a_wcn, b_wcn;
  logic [1:0] a_st, b_st;

  mst_t ma, mb;
  int checks = 0;
  int errors = 0;

  workout_sequencer #(
    .CN_W(9), .TI_W(7), .WORK_SEC(3), .REST_SEC(2), .LONG_REST_SEC(4),
    .LONG_EVERY(2), .NUM_EX(3)
  ) dut_a (
    .Clk(clk), .Re(re), .Tick(tick), .St(st), .Sk(sk), .Pa(pa), .Tgt(tgt),
    .Bu(a_bu), .Cn(a_cn), .Ti(a_ti), .WCn(a_wcn), .St_o(a_st)
  );

  workout_sequencer #(
    .CN_W(9), .TI_W(4), .WORK_SEC(5), .REST_SEC(3), .LONG_REST_SEC(7),
    .LONG_EVERY(0), .NUM_EX(10)
  ) dut_b (
    .Clk(clk), .Re(re), .Tick(tick), .St(st), .Sk(sk), .Pa(pa), .Tgt(tgt),
    .Bu(b_bu), .Cn(b_cn), .Ti(b_ti), .WCn(b_wcn), .St_o(b_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mst_t m_reset();
    mst_t s;
    s.st = 0; s.cn = 0; s.ti = 0; s.wcn = 0; s.bu = 0; s.tgt = 0; s.ret = 1;
    return s;
  endfunction

  function automatic mst_t m_finish(mst_t s);
    mst_t n = s;
    n.bu = 3; n.ti = 0; n.wcn = 0; n.st = 0;
    return n;
  endfunction

  function automatic mst_t m_advance(mst_t s, prm_t p, int bu);
    mst_t n = s;
    n.cn  = s.cn + 1;
    n.ti  = p.work;
    n.wcn = (s.wcn + 1) % p.nex;
    n.bu  = bu;
    n.st  = 1;
    return n;
  endfunction

  // One clock of the session rules: 0 IDLE, 1 WORK, 2 REST, 3 PAUSED.
  function automatic mst_t m_step(mst_t s, prm_t p, bit i_st, bit i_sk,
                                  bit i_pa, bit i_tick, int i_tgt);
    mst_t n = s;
    n.bu = 0;
    case (s.st)
      0: if (i_st && i_tgt != 0) begin
           n.tgt = i_tgt; n.cn = 1; n.ti = p.work; n.wcn = 0; n.st = 1;
         end
      1: if (i_sk) n = (s.cn == s.tgt) ? m_finish(s) : m_advance(s, p, 2);
         else if (i_pa) begin n.ret = 1; n.st = 3; end
         else if (i_tick) begin
           if (s.ti > 0) n.ti = s.ti - 1;
           else if (s.cn == s.tgt) n = m_finish(s);
           else begin
             n.st = 2;
             n.ti = (p.every != 0 && s.cn % p.every == 0) ? p.lrest : p.rest;
           end
         end
      2: if (i_sk) n = m_advance(s, p, 2);
         else if (i_pa) begin n.ret = 2; n.st = 3; end
         else if (i_tick) begin
           if (s.ti > 0) n.ti = s.ti - 1;
           else n = m_advance(s, p, 1);
         end
      default: if (i_pa) n.st = s.ret;
    endcase
    return n;
  endfunction

  // Reference models follow the same clock and asynchronous reset as the DUTs.
  always @(posedge clk or negedge re) begin
    if (!re) begin
      ma <= m_reset();
      mb <= m_reset();
    end else begin
      ma <= m_step(ma, PRM_A, st, sk, pa, tick, int'(tgt));
      mb <= m_step(mb, PRM_B, st, sk, pa, tick, int'(tgt));
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic pin(input string nm, input int dut_v, input int mdl_v, input int exp);
    chk({nm, "_dut"}, dut_v, exp);
    chk({nm, "_model"}, mdl_v, exp);
  endtask

  task automatic compare_all();
    chk("a_st",  int'(a_st),  ma.st);
    chk("a_cn",  int'(a_cn),  ma.cn);
    chk("a_ti",  int'(a_ti),  ma.ti);
    chk("a_wcn", int'(a_wcn), ma.wcn);
    chk("a_bu",  int'(a_bu),  ma.bu);
    chk("b_st",  int'(b_st),  mb.st);
    chk("b_cn",  int'(b_cn),  mb.cn);
    chk("b_ti",  int'(b_ti),  mb.ti);
    chk("b_wcn", int'(b_wcn), mb.wcn);
    chk("b_bu",  int'(b_bu),  mb.bu);
  endtask

  // Drive one cycle of inputs just after a falling edge, then check at the next one.
  task automatic step(input bit s, input bit k, input bit p, input bit t, input int g);
    st = s; sk = k; pa = p; tick = t; tgt = 9'(g);
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
  endtask

  initial begin
    re = 1'b0; st = 0; sk = 0; pa = 0; tick = 0; tgt = '0;
    repeat (2) @(negedge clk);
    pin("rst_st", int'(a_st), ma.st, 0);
    pin("rst_cn", int'(a_cn), ma.cn, 0);
    pin("rst_ti", int'(a_ti), ma.ti, 0);
    re = 1'b1;
    step(0, 0, 0, 0, 0);

    // Normal run, target 2: no rest after the final set.
    step(1, 0, 0, 0, 2);
    pin("run_st", int'(a_st), ma.st, 1);
    pin("run_ti", int'(a_ti), ma.ti, 3);
    ticks(3);
    pin("run_ti0", int'(a_ti), ma.ti, 0);
    ticks(1);
    pin("run_rest", int'(a_st), ma.st, 2);
    pin("run_rest_ti", int'(a_ti), ma.ti, 2);
    ticks(3);
    pin("run_bu01", int'(a_bu), ma.bu, 1);
    pin("run_cn2", int'(a_cn), ma.cn, 2);
    pin("run_wcn1", int'(a_wcn), ma.wcn, 1);
    ticks(4);
    pin("run_done_bu", int'(a_bu), ma.bu, 3);
    pin("run_done_st", int'(a_st), ma.st, 0);
    pin("run_done_cn", int'(a_cn), ma.cn, 2);
    step(0, 0, 0, 1, 0);
    pin("run_bu_pulse", int'(a_bu), ma.bu, 0);

    // Long rest every second set, target 4.
    step(1, 0, 0, 0, 4);
    ticks(4);
    pin("long_set1", int'(a_ti), ma.ti, 2);
    ticks(3 + 4);
    pin("long_set2", int'(a_ti), ma.ti, 4);
    ticks(5 + 4);
    pin("long_set3", int'(a_ti), ma.ti, 2);
    step(0, 1, 0, 0, 0);
    pin("long_skip_cn", int'(a_cn), ma.cn, 4);
    step(0, 1, 0, 0, 0);
    pin("long_skip_done", int'(a_bu), ma.bu, 3);

    // Skip in WORK, target 3.
    step(1, 0, 0, 0, 3);
    step(0, 1, 0, 0, 0);
    pin("skip_bu", int'(a_bu), ma.bu, 2);
    pin("skip_cn", int'(a_cn), ma.cn, 2);
    pin("skip_ti", int'(a_ti), ma.ti, 3);
    pin("skip_wcn", int'(a_wcn), ma.wcn, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    pin("skip_last_bu", int'(a_bu), ma.bu, 3);
    pin("skip_last_st", int'(a_st), ma.st, 0);

    // Pause in REST at Ti=1, then a skip/tick collision.
    step(1, 0, 0, 0, 3);
    ticks(5);
    pin("pause_pre_ti", int'(a_ti), ma.ti, 1);
    step(0, 0, 1, 0, 0);
    pin("pause_st", int'(a_st), ma.st, 3);
    ticks(5);
    step(0, 1, 0, 0, 0);
    pin("pause_skip_bu", int'(a_bu), ma.bu, 0);
    pin("pause_hold_ti", int'(a_ti), ma.ti, 1);
    step(0, 0, 1, 0, 0);
    pin("resume_st", int'(a_st), ma.st, 2);
    pin("resume_ti", int'(a_ti), ma.ti, 1);
    step(0, 1, 0, 1, 0);
    pin("coll_ti", int'(a_ti), ma.ti, 3);
    pin("coll_cn", int'(a_cn), ma.cn, 2);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // Wheel wrap with NUM_EX=3, target 5.
    step(1, 0, 0, 0, 5);
    step(0, 1, 0, 0, 0);
    pin("wheel1", int'(a_wcn), ma.wcn, 1);
    step(0, 1, 0, 0, 0);
    pin("wheel2", int'(a_wcn), ma.wcn, 2);
    step(0, 1, 0, 1, 0);
    pin("wheel0", int'(a_wcn), ma.wcn, 0);
    pin("wheel_ti", int'(a_ti), ma.ti, 3);
    step(0, 1, 0, 0, 0);
    pin("wheel1b", int'(a_wcn), ma.wcn, 1);
    pin("wheel_cn5", int'(a_cn), ma.cn, 5);
    ticks(4);
    pin("wheel_done", int'(a_bu), ma.bu, 3);

    // Asynchronous reset in REST, then a zero-target start.
    step(1, 0, 0, 0, 5);
    ticks(4);
    pin("ar_pre_st", int'(a_st), ma.st, 2);
    #2 re = 1'b0;
    #1;
    pin("ar_st", int'(a_st), ma.st, 0);
    pin("ar_cn", int'(a_cn), ma.cn, 0);
    pin("ar_ti", int'(a_ti), ma.ti, 0);
    pin("ar_wcn", int'(a_wcn), ma.wcn, 0);
    @(negedge clk);
    re = 1'b1;
    step(1, 0, 0, 0, 0);
    pin("zero_tgt_st", int'(a_st), ma.st, 0);

    // Randomised sessions.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 re = 1'b0;
        @(negedge clk);
        compare_all();
        re = 1'b1;
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 13) == 0,
           $urandom_range(0, 17) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/workout_sequencer.md
# workout_sequencer

Parametrised successor to the fixed 45 s/15 s set controller. Sequences a session of work and rest intervals up to a sampled set target, driven by a one-second tick enable instead of a per-second clock. Adds configurable interval lengths, a periodic long rest, pause/resume, no rest after the final set, and a configurable exercise-wheel size. Sits between the target calculator (which supplies `Tgt`) and the display/buzzer drivers.

## Interface
- `CN_W`, default 9: width of the set target and set counter.
- `TI_W`, default 7: width of the interval timer.
- `WORK_SEC`, default 45: work interval length in ticks.
- `REST_SEC`, default 15: normal rest length in ticks.
- `LONG_REST_SEC`, default 60: long rest length in ticks.
- `LONG_EVERY`, default 5: a long rest follows every set whose number is a multiple of this value; 0 disables long rests.
- `NUM_EX`, default 10: exercise-wheel size; `WCn` wraps at `NUM_EX-1`.
- `Clk` input 1: clock; all state changes on the rising edge.
- `Re` input 1: asynchronous, active-low reset.
- `Tick` input 1: one-cycle one-second enable.
- `St` input 1: start request.
- `Sk` input 1: skip request.
- `Pa` input 1: pause/resume toggle request.
- `Tgt` input `CN_W`: set target; sampled only when a session starts.
- `Bu` output 2: buzzer code, one-cycle pulse (01 = rest over, 10 = skipped, 11 = session done).
- `Cn` output `CN_W`: current set number.
- `Ti` output `TI_W`: remaining ticks in the current interval.
- `WCn` output 4: exercise index, 0..`NUM_EX-1`.
- `St_o` output 2: state (00 IDLE, 01 WORK, 10 REST, 11 PAUSED).

## Operation
- **Reset** (`Re`=0): `Bu`=0, `Cn`=0, `Ti`=0, `WCn`=0, state IDLE, internal target register=0, return-state register=WORK. Reset takes effect immediately, including mid-session.
- **Input priority per cycle:** `Sk` > `Pa` > `Tick`. `St` is decoded only in IDLE.
- **`Bu`** is 00 in every cycle unless this section states otherwise.
- **IDLE:**
  - `St`=1 with `Tgt`≠0: latch `Tgt`; `Cn`=1, `Ti`=`WORK_SEC`, `WCn`=0; go to WORK.
  - `St`=1 with `Tgt`=0: ignored.
  - `Sk`, `Pa` and `Tick` are ignored.
- **Finish action:** `Bu`=11, `Ti`=0, `WCn`=0; `Cn` holds its value; go to IDLE.
- **Advance action:** `Cn`=`Cn`+1; `Ti`=`WORK_SEC`; `WCn`=0 if `WCn`=`NUM_EX-1`, else `WCn`+1; go to WORK.
- **WORK:**
  - `Sk`: if `Cn`=target, finish. Otherwise advance with `Bu`=10.
  - `Pa`: save WORK as the return state; go to PAUSED; hold all counters.
  - `Tick` with `Ti`>0: `Ti`-1.
  - `Tick` with `Ti`=0 and `Cn`=target: finish. No rest follows the final set.
  - `Tick` with `Ti`=0 otherwise: go to REST. `Ti`=`LONG_REST_SEC` if `LONG_EVERY`≠0 and `Cn` mod `LONG_EVERY`=0, else `REST_SEC`.
- **REST:**
  - `Sk`: advance with `Bu`=10. `Cn`<target always holds in REST.
  - `Pa`: save REST as the return state; go to PAUSED.
  - `Tick` with `Ti`>0: `Ti`-1.
  - `Tick` with `Ti`=0: advance with `Bu`=01.
- **PAUSED:**
  - `Pa`: return to the saved state with counters unchanged.
  - `Sk` and `Tick` are ignored.
- **Arithmetic:** `Cn` never exceeds the target, so no `CN_W` overflow occurs. `WCn` wraps explicitly. All interval parameters must be < 2^`TI_W`; an elaboration-time check enforces this. The long-rest modulo uses a counter that resets on each long rest, not a divider.

## Timing
- All outputs are registered and update on the `Clk` edge after the qualifying input cycle; latency is one cycle.
- A `Tick` coinciding with `Sk` or `Pa` is dropped; it does not also decrement `Ti`.
- `St`, `Sk` and `Pa` are level-sampled each cycle. Each cycle they are high counts as one request; upstream edge-detects.
- Interval length: WORK lasts `WORK_SEC`+1 ticks from entry, because the `Ti`=0 tick causes the transition. REST behaves the same way.
- A change on `Tgt` during a session has no effect.

## Test plan
- **Normal run** (`WORK_SEC`=3, `REST_SEC`=2, `LONG_EVERY`=0, `Tgt`=2): `St`, then ticks. Expect WORK `Ti` 3,2,1,0; REST `Ti`=2; `Bu`=01 with `Cn`=2; WORK; then `Bu`=11 and IDLE with no second rest, `Cn`=2.
- **Long rest** (`LONG_EVERY`=2, `LONG_SEC`=4, `Tgt`=4): expect REST after set 1 loads `Ti`=2, after set 2 loads `Ti`=4, after set 3 loads `Ti`=2.
- **Skip:** `Sk` in WORK of set 1 with `Tgt`=3 → `Bu`=10, `Cn`=2, `Ti`=3, `WCn`=1. `Sk` in the WORK of set 3 → `Bu`=11, IDLE.
- **Pause:** `Pa` in REST at `Ti`=1, 5 ticks, `Pa` → back in REST with `Ti`=1. `Sk` while PAUSED → no change, `Bu`=00.
- **Wheel wrap and tick collision** (`NUM_EX`=3, `Tgt`=5, repeated `Sk`): `WCn` 0,1,2,0,1. `Sk` and `Tick` in the same cycle give a single advance, with `Ti`=`WORK_SEC` not decremented.
- **Reset mid-session:** `Re`=0 asynchronously in REST → immediately `Cn`=0, `Ti`=0, `WCn`=0, `Bu`=0, IDLE. `St` with `Tgt`=0 → stays IDLE.
